// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the fetch controller and the instruction decoder.
// Holds the datapath width constants, the 16-bit instruction opcode encodings,
// the ALU control encodings and the fetch/execute FSM state type.
package cpu_pkg;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  // Opcodes 0x0-0x3 are the register form and 0x4-0x7 the immediate form
  // of the same four ALU operations; op[1:0] is the ALU control in both.
  // 0x8-0xE are NOPs and 0xF halts the machine.
  typedef enum logic [3:0] {
    OP_AND  = 4'h0,
    OP_OR   = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_ANDI = 4'h4,
    OP_ORI  = 4'h5,
    OP_ADDI = 4'h6,
    OP_SUBI = 4'h7,
    OP_HALT = 4'hF
  } op_t;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } fetch_state_t;

  // Any opcode with bit 3 clear produces a register write.
  function automatic logic op_writes(input logic [3:0] op);
    return (op[3] == 1'b0);
  endfunction

  // Opcodes 0x4-0x7 take their second ALU operand from the immediate.
  function automatic logic op_is_imm(input logic [3:0] op);
    return (op[3:2] == 2'b01);
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: purely combinational decode of the instruction register.
// Ports:
//   ir          in   16  latched instruction word
//   ra1, ra2    out  4   register file read addresses
//   wa          out  4   register file write address
//   ext_data    out  8   immediate operand (zero unless immediate form)
//   alu_control out  2   ALU operation
//   alu_src     out  1   0 = register B, 1 = ext_data
//   is_write    out  1   instruction writes the register file
//   is_halt     out  1   instruction is HALT
// NOP and HALT words decode to all-zero addresses/controls so that the
// outputs are quiet whenever nothing is being written. A zero IR (reset)
// also decodes to all-zero fields.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ra1,
  output logic [ADDR_W-1:0]  ra2,
  output logic [ADDR_W-1:0]  wa,
  output logic [DATA_W-1:0]  ext_data,
  output logic [1:0]         alu_control,
  output logic               alu_src,
  output logic               is_write,
  output logic               is_halt
);

  logic [3:0]        op;
  logic [ADDR_W-1:0] rd;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [DATA_W-1:0] imm8;

  assign op   = ir[15:12];
  assign rd   = ir[11:8];
  assign rs1  = ir[7:4];
  assign rs2  = ir[3:0];
  assign imm8 = ir[7:0];

  // Field selection by instruction form. The immediate form reads its
  // first operand from rd (read-modify-write of the destination).
  always_comb begin
    ra1         = '0;
    ra2         = '0;
    wa          = '0;
    ext_data    = '0;
    alu_control = ALU_AND;
    alu_src     = 1'b0;
    is_write    = 1'b0;
    is_halt     = (op == OP_HALT);
    if (op_writes(op)) begin
      is_write    = 1'b1;
      wa          = rd;
      alu_control = op[1:0];
      if (op_is_imm(op)) begin
        ra1      = rd;
        alu_src  = 1'b1;
        ext_data = imm8;
      end else begin
        ra1 = rs1;
        ra2 = rs2;
      end
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: fetch/decode/execute sequencer for a tiny register CPU.
// Owns the FSM, the program counter and the instruction register; the
// instruction fields are decoded by instr_decoder.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   start             leaves IDLE and begins fetching at pc
//   imem_req/addr     instruction fetch request and address (= pc)
//   imem_ack/rdata    fetch response; data is taken on the acknowledged edge
//   RA1, RA2, WA      register file addresses
//   ext_data          immediate operand to the datapath
//   ALUControl/ALUSrc ALU operation and operand-B select
//   RegWrite          one-cycle write strobe in EXEC
//   busy, halted      status (FETCH/DECODE/EXEC, HALT)
//   pc                current program counter
module instr_fetch_ctrl
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  RA1,
  output logic [ADDR_W-1:0]  RA2,
  output logic [ADDR_W-1:0]  WA,
  output logic [DATA_W-1:0]  ext_data,
  output logic [1:0]         ALUControl,
  output logic               ALUSrc,
  output logic               RegWrite,
  output logic               busy,
  output logic               halted,
  output logic [PC_W-1:0]    pc
);

  fetch_state_t       state;
  logic [INSTR_W-1:0] ir;
  logic               dec_is_write;
  logic               dec_is_halt;

  assign imem_addr = pc;

  // Decoded outputs come straight from IR, which only changes on a fetch
  // acknowledge, so they stay steady through DECODE and EXEC.
  instr_decoder u_decoder (
    .ir          (ir),
    .ra1         (RA1),
    .ra2         (RA2),
    .wa          (WA),
    .ext_data    (ext_data),
    .alu_control (ALUControl),
    .alu_src     (ALUSrc),
    .is_write    (dec_is_write),
    .is_halt     (dec_is_halt)
  );

  // Main sequencer. Status outputs are registered alongside the state so
  // they change on the same edge as the state they describe. RegWrite is
  // raised on the DECODE->EXEC edge and dropped on the edge leaving EXEC,
  // giving exactly one strobe per writing instruction. PC advances only
  // when EXEC returns to FETCH, never when entering HALT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      pc       <= '0;
      ir       <= '0;
      imem_req <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
      RegWrite <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_FETCH;
            imem_req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (imem_ack) begin
            state    <= ST_DECODE;
            ir       <= imem_rdata;
            imem_req <= 1'b0;
          end
        end
        ST_DECODE: begin
          state    <= ST_EXEC;
          RegWrite <= dec_is_write;
        end
        ST_EXEC: begin
          RegWrite <= 1'b0;
          if (dec_is_halt) begin
            state  <= ST_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state    <= ST_FETCH;
            pc       <= pc + PC_W'(1);
            imem_req <= 1'b1;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state    <= ST_IDLE;
          imem_req <= 1'b0;
          busy     <= 1'b0;
          halted   <= 1'b0;
          RegWrite <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: self-checking bench for instr_fetch_ctrl.
// An instruction memory responder answers fetches after a chosen or random
// delay; a monitor records fetch addresses, request lengths and every
// register write, and runs a small register file / ALU model on the writes.
// Expected results come from a program-level model that walks the program
// using the instruction set rules.
module tb_instr_fetch_ctrl;
  import cpu_pkg::*;

  typedef struct packed {
    logic [3:0] wa;
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic       src;
    logic [1:0] ctl;
    logic [7:0] ext;
  } dec_t;

  typedef struct {
    logic [15:0] word;
    int          delay;
    bit          expWrite;
    dec_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [3:0]  RA1, RA2, WA;
  logic [7:0]  ext_data;
  logic [1:0]  ALUControl;
  logic        ALUSrc;
  logic        RegWrite;
  logic        busy;
  logic        halted;
  logic [7:0]  pc;

  logic [15:0] mem [256];
  int          fixedDelay = 0;
  bit          noiseAck = 1'b0;
  int          waitCnt = 0;
  int          curDelay = 0;

  dec_t        writesQ[$];
  logic [7:0]  addrQ[$];
  int          reqLenQ[$];
  int          reqRun = 0;
  logic [7:0]  regs [16];
  logic [7:0]  lastAlu = '0;

  int          passCount = 0;
  int          checkCount = 0;
  vec_t        vecs[10];

  always #5 clk = ~clk;

  instr_fetch_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .RA1        (RA1),
    .RA2        (RA2),
    .WA         (WA),
    .ext_data   (ext_data),
    .ALUControl (ALUControl),
    .ALUSrc     (ALUSrc),
    .RegWrite   (RegWrite),
    .busy       (busy),
    .halted     (halted),
    .pc         (pc)
  );

  // Instruction memory: holds the response off for curDelay cycles of an
  // active request, then acks with mem[addr]. Outside a request it may
  // toggle a stray ack with junk data, which the DUT must ignore.
  always @(negedge clk) begin
    if (imem_req && !reset) begin
      if (waitCnt >= curDelay) begin
        imem_ack   = 1'b1;
        imem_rdata = mem[imem_addr];
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 16'($urandom);
        waitCnt++;
      end
    end else begin
      waitCnt    = 0;
      curDelay   = (fixedDelay >= 0) ? fixedDelay : int'($urandom_range(0, 3));
      imem_ack   = noiseAck ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_rdata = 16'($urandom);
    end
  end

  // Monitor: logs fetch addresses, request lengths and each write, and
  // applies the write to a behavioural register file with its ALU.
  always @(negedge clk) begin
    logic [7:0] b;
    logic [7:0] r;
    if (reset) begin
      reqRun = 0;
    end else begin
      if (imem_req) begin
        if (reqRun == 0) addrQ.push_back(imem_addr);
        reqRun++;
      end else if (reqRun != 0) begin
        reqLenQ.push_back(reqRun);
        reqRun = 0;
      end
      if (RegWrite) begin
        writesQ.push_back({WA, RA1, RA2, ALUSrc, ALUControl, ext_data});
        b = ALUSrc ? ext_data : regs[RA2];
        case (ALUControl)
          2'b00:   r = regs[RA1] & b;
          2'b01:   r = regs[RA1] | b;
          2'b10:   r = regs[RA1] + b;
          default: r = regs[RA1] - b;
        endcase
        regs[WA] = r;
        lastAlu  = r;
      end
    end
  end

  // Safety net in case some wait loop is wrong.
  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic dec_t mkDec(input logic [3:0] wa, input logic [3:0] ra1,
                                 input logic [3:0] ra2, input logic src,
                                 input logic [1:0] ctl, input logic [7:0] ext);
    return {wa, ra1, ra2, src, ctl, ext};
  endfunction

  // Expected decode of a writing instruction from the instruction set rules.
  function automatic dec_t expDecode(input logic [15:0] w);
    if (w[15:12] >= 4'h4)
      return mkDec(w[11:8], w[11:8], 4'h0, 1'b1, w[13:12], w[7:0]);
    return mkDec(w[11:8], w[7:4], w[3:0], 1'b0, w[13:12], 8'h00);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Register-form writes leave ext_data unspecified, so it is masked.
  task automatic checkDecode(input string name, input dec_t act, input dec_t exp,
                             input bit isImm);
    dec_t a;
    dec_t e;
    a = act;
    e = exp;
    if (!isImm) begin
      a.ext = '0;
      e.ext = '0;
    end
    checkOutput(name, {9'b0, a}, {9'b0, e});
  endtask

  task automatic doReset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    writesQ.delete();
    addrQ.delete();
    reqLenQ.delete();
    for (int i = 0; i < 16; i++) regs[i] = '0;
    lastAlu = '0;
    reset = 1'b0;
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput(name, {RegWrite, imem_req, busy, halted, RA1, RA2, WA, ext_data,
                       ALUControl, ALUSrc, pc}, 32'h0);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitHalted(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("halt_reached", {31'b0, halted}, 32'h1);
  endtask

  task automatic fillMem(input logic [15:0] w);
    for (int i = 0; i < 256; i++) mem[i] = w;
  endtask

  // Runs one table vector: the word at address 0 followed by HALT.
  task automatic applyStimulus(input vec_t v, input int idx);
    fillMem(16'hF000);
    mem[0]     = v.word;
    fixedDelay = v.delay;
    noiseAck   = 1'b0;
    doReset();
    pulseStart();
    waitHalted(60);
    checkOutput($sformatf("vec%0d_writes", idx), writesQ.size(), v.expWrite ? 1 : 0);
    if (v.expWrite && writesQ.size() > 0)
      checkDecode($sformatf("vec%0d_decode", idx), writesQ[0], v.exp, v.word[14]);
    checkOutput($sformatf("vec%0d_req_len", idx),
                (reqLenQ.size() > 0) ? reqLenQ[0] : -1, v.delay + 1);
    checkOutput($sformatf("vec%0d_pc", idx), pc, 8'h01);
  endtask

  // Randomized program: ops 0x0-0xE at 0..len-1, HALT at len. The model
  // walks the program to predict the write sequence and fetch addresses.
  task automatic randomProgram(input int idx);
    int         len;
    logic [15:0] w;
    logic [7:0]  mpc;
    dec_t        expQ[$];
    bit          immQ[$];
    int          nFetch;
    len = $urandom_range(2, 24);
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < len; i++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'hF) w[15:12] = 4'($urandom_range(0, 14));
      mem[i] = w;
    end
    mem[len][15:12] = 4'hF;
    mpc = 8'h00;
    nFetch = 0;
    for (int s = 0; s < 300; s++) begin
      nFetch++;
      w = mem[mpc];
      if (w[15:12] == 4'hF) break;
      if (w[15:12] <= 4'h7) begin
        expQ.push_back(expDecode(w));
        immQ.push_back(w[14]);
      end
      mpc = mpc + 8'd1;
    end
    fixedDelay = -1;
    noiseAck   = 1'b1;
    doReset();
    pulseStart();
    waitHalted(len * 12 + 40);
    noiseAck = 1'b0;
    checkOutput($sformatf("rnd%0d_nwrites", idx), writesQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < writesQ.size(); i++)
      checkDecode($sformatf("rnd%0d_write%0d", idx, i), writesQ[i], expQ[i], immQ[i]);
    checkOutput($sformatf("rnd%0d_nfetch", idx), addrQ.size(), nFetch);
    for (int i = 0; i < addrQ.size(); i++)
      checkOutput($sformatf("rnd%0d_addr%0d", idx, i), addrQ[i], i);
    checkOutput($sformatf("rnd%0d_pc", idx), pc, mpc);
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    start      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    fillMem(16'hF000);

    vecs[0] = '{16'h6205, 0, 1'b1, mkDec(4'd2,  4'd2,  4'd0,  1'b1, 2'b10, 8'h05)};
    vecs[1] = '{16'h3A12, 3, 1'b1, mkDec(4'd10, 4'd1,  4'd2,  1'b0, 2'b11, 8'h00)};
    vecs[2] = '{16'h0123, 1, 1'b1, mkDec(4'd1,  4'd2,  4'd3,  1'b0, 2'b00, 8'h00)};
    vecs[3] = '{16'h1F0E, 2, 1'b1, mkDec(4'd15, 4'd0,  4'd14, 1'b0, 2'b01, 8'h00)};
    vecs[4] = '{16'h2456, 0, 1'b1, mkDec(4'd4,  4'd5,  4'd6,  1'b0, 2'b10, 8'h00)};
    vecs[5] = '{16'h4A9C, 1, 1'b1, mkDec(4'd10, 4'd10, 4'd0,  1'b1, 2'b00, 8'h9C)};
    vecs[6] = '{16'h5300, 0, 1'b1, mkDec(4'd3,  4'd3,  4'd0,  1'b1, 2'b01, 8'h00)};
    vecs[7] = '{16'h7FFF, 2, 1'b1, mkDec(4'd15, 4'd15, 4'd0,  1'b1, 2'b11, 8'hFF)};
    vecs[8] = '{16'h8123, 0, 1'b0, mkDec(4'd0,  4'd0,  4'd0,  1'b0, 2'b00, 8'h00)};
    vecs[9] = '{16'hE0F1, 1, 1'b0, mkDec(4'd0,  4'd0,  4'd0,  1'b0, 2'b00, 8'h00)};

    // Reset values and single-cycle-ack ADDI timeline.
    mem[0] = 16'h6205;
    fixedDelay = 0;
    doReset();
    checkResetOutputs("reset_outputs");
    pulseStart();
    checkOutput("addi_req", {imem_req, busy}, 2'b11);
    checkOutput("addi_addr", imem_addr, 8'h00);
    @(posedge clk); #1;
    checkOutput("addi_decode_nowrite", {RegWrite, pc}, 9'h000);
    @(posedge clk); #1;
    checkOutput("addi_exec_write", RegWrite, 1'b1);
    checkDecode("addi_exec_fields", {WA, RA1, RA2, ALUSrc, ALUControl, ext_data},
                mkDec(4'd2, 4'd2, 4'd0, 1'b1, 2'b10, 8'h05), 1'b1);
    @(posedge clk); #1;
    checkOutput("addi_pc_after", {RegWrite, pc}, 9'h001);

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);

    // Program with a NOP and HALT; afterwards start and acks are ignored.
    fillMem(16'hF000);
    mem[0] = 16'h4170;
    mem[1] = 16'h9000;
    fixedDelay = 1;
    noiseAck = 1'b0;
    doReset();
    pulseStart();
    waitHalted(60);
    checkOutput("halt_writes", writesQ.size(), 1);
    if (writesQ.size() > 0)
      checkDecode("halt_w0", writesQ[0], mkDec(4'd1, 4'd1, 4'd0, 1'b1, 2'b00, 8'h70), 1'b1);
    checkOutput("halt_pc", pc, 8'h02);
    noiseAck = 1'b1;
    pulseStart();
    repeat (6) @(posedge clk);
    #1;
    noiseAck = 1'b0;
    checkOutput("halt_sticky", {halted, busy, imem_req, RegWrite}, 4'b1000);
    checkOutput("halt_pc_stays", pc, 8'h02);
    checkOutput("halt_writes_after", writesQ.size(), 1);
    checkOutput("halt_fetches", addrQ.size(), 3);

    // Reset while FETCH waits for an ack, with pc already advanced.
    fillMem(16'h8000);
    mem[1] = 16'h1234;
    fixedDelay = 0;
    doReset();
    pulseStart();
    n = 0;
    while (!(busy && !imem_req) && n < 20) begin @(posedge clk); #1; n++; end
    fixedDelay = 20;
    n = 0;
    while (!imem_req && n < 20) begin @(posedge clk); #1; n++; end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midfetch_waiting", {imem_req, pc}, 9'h101);
    reset = 1'b1;
    @(posedge clk); #1;
    checkResetOutputs("midfetch_reset");
    reset = 1'b0;
    fixedDelay = 0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("midfetch_idle", {busy, imem_req, halted}, 3'b000);
    checkOutput("midfetch_nowrite", writesQ.size(), 0);

    // PC wraps from 0xFF to 0x00 across a NOP.
    fillMem(16'h8000);
    fixedDelay = 0;
    doReset();
    pulseStart();
    n = 0;
    while (pc != 8'hFF && n < 1000) begin @(posedge clk); #1; n++; end
    checkOutput("wrap_reach_ff", pc, 8'hFF);
    n = 0;
    while (imem_req && n < 10) begin @(posedge clk); #1; n++; end
    n = 0;
    while (!imem_req && n < 10) begin @(posedge clk); #1; n++; end
    checkOutput("wrap_addr", {imem_req, imem_addr}, 9'h100);
    checkOutput("wrap_nowrite", writesQ.size(), 0);

    // Datapath integration: ADDI r3,0x0F then OR r4,r3,r3.
    fillMem(16'hF000);
    mem[0] = 16'h630F;
    mem[1] = 16'h1433;
    fixedDelay = 0;
    doReset();
    pulseStart();
    waitHalted(60);
    checkOutput("alu_writes", writesQ.size(), 2);
    checkOutput("alu_result", lastAlu, 8'h0F);
    checkOutput("alu_r4", regs[4], 8'h0F);

    for (int p = 0; p < 8; p++) randomProgram(p);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
